// File: rtl/pause_overlay_ctrl_pkg.sv
// Shared types and the 3x5 countdown font for the pause overlay.
package flappy_pkg;

   typedef enum logic [1:0] {RUN, PAUSED, COUNT} pause_state_t;

   localparam int FONT_ROWS = 5;
   localparam int FONT_COLS = 3;

   // Index [r][c]: r = 0 is the top glyph row, c = 0 the lowest matrix column used.
   typedef logic [FONT_ROWS-1:0][FONT_COLS-1:0] font_t;

   localparam font_t FONT_1 = {3'b111, 3'b010, 3'b010, 3'b011, 3'b010};
   localparam font_t FONT_2 = {3'b111, 3'b001, 3'b111, 3'b100, 3'b111};
   localparam font_t FONT_3 = {3'b111, 3'b100, 3'b111, 3'b100, 3'b111};

   function automatic font_t digit_font(input logic [1:0] digit);
      case (digit)
         2'd1:    return FONT_1;
         2'd2:    return FONT_2;
         2'd3:    return FONT_3;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/pause_overlay_ctrl_if.sv
// Frame path and status signals between the game frame source, the pause controller and the driver.
interface pause_overlay_if #(
   parameter int ROWS = 8,
   parameter int COLS = 8
);
   logic                      pause_btn;
   logic [ROWS-1:0][COLS-1:0] red_in;
   logic [ROWS-1:0][COLS-1:0] green_in;
   logic [ROWS-1:0][COLS-1:0] red_out;
   logic [ROWS-1:0][COLS-1:0] green_out;
   logic                      game_en;
   logic                      paused;

   modport master (
      output pause_btn, red_in, green_in,
      input  red_out, green_out, game_en, paused
   );

   modport slave (
      input  pause_btn, red_in, green_in,
      output red_out, green_out, game_en, paused
   );
endinterface

// File: rtl/pause_overlay_ctrl_glyph_gen.sv
// Combinational overlay planes: blinking pause bars while paused, red countdown digit while counting.
module pause_glyph_gen
   import flappy_pkg::*;
#(
   parameter int ROWS = 8,
   parameter int COLS = 8
) (
   input  logic                      icon_on,
   input  pause_state_t              state,
   input  logic [1:0]                digit,
   output logic [ROWS-1:0][COLS-1:0] red,
   output logic [ROWS-1:0][COLS-1:0] green
);
   localparam int DIGIT_ROW0 = ROWS/2 - 3;
   localparam int DIGIT_COL0 = COLS/2 - 2;

   logic [ROWS-1:0][COLS-1:0] pause_plane;
   logic [ROWS-1:0][COLS-1:0] digit_plane;
   font_t                     font;

   always_comb begin
      pause_plane = '0;
      digit_plane = '0;
      font        = digit_font(digit);

      // Two vertical bars, two columns wide, with a one-column gap at COLS/2-1.
      for (int r = 1; r <= ROWS-2; r++) begin
         pause_plane[r][COLS/2-3] = 1'b1;
         pause_plane[r][COLS/2-2] = 1'b1;
         pause_plane[r][COLS/2]   = 1'b1;
         pause_plane[r][COLS/2+1] = 1'b1;
      end

      for (int r = 0; r < FONT_ROWS; r++) begin
         for (int c = 0; c < FONT_COLS; c++) begin
            digit_plane[DIGIT_ROW0+r][DIGIT_COL0+c] = font[r][c];
         end
      end

      red   = '0;
      green = '0;
      case (state)
         PAUSED: begin
            if (icon_on) begin
               red   = pause_plane;
               green = pause_plane;
            end
         end
         COUNT:   red = digit_plane;
         default: ;
      endcase
   end

endmodule

// File: rtl/pause_overlay_ctrl.sv
// Pause controller and LED-matrix overlay between the game frame generator and the matrix driver.
// Define PAUSE_COUNTDOWN_EN to insert a 3-2-1 countdown between un-pause and resumed play.
module pause_overlay_ctrl #(
   parameter int ROWS         = 8,
   parameter int COLS         = 8,
   parameter int BLINK_CYCLES = 25000000,
   parameter int COUNT_CYCLES = 50000000
) (
   input  logic           clk,
   input  logic           reset,
   pause_overlay_if.slave bus
);
   import flappy_pkg::*;

   if (ROWS < 7 || COLS < 6 || BLINK_CYCLES < 2 || COUNT_CYCLES < 2) begin : g_param_check
      $error("pause_overlay_ctrl: parameter outside legal range");
   end

   localparam int                 BLINK_W    = $clog2(BLINK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   pause_state_t              state, state_nxt;
   logic                      btn_q;
   logic                      btn_armed;
   logic                      press;
   logic [BLINK_W-1:0]        blink_cnt, blink_nxt;
   logic                      icon_on, icon_nxt;
   logic [1:0]                glyph_digit;
   logic [ROWS-1:0][COLS-1:0] ov_red, ov_green;
   logic [ROWS-1:0][COLS-1:0] red_q, green_q;
   logic                      game_en_q, paused_q;

`ifdef PAUSE_COUNTDOWN_EN
   localparam int                 COUNT_W    = $clog2(COUNT_CYCLES);
   localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(COUNT_CYCLES - 1);

   logic [COUNT_W-1:0] cnt, cnt_nxt;
   logic [1:0]         digit, digit_nxt;
`endif

   // btn_armed masks the first post-reset cycle so a key held through reset is only loaded, not toggled.
   assign press = bus.pause_btn & ~btn_q & btn_armed;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         btn_q     <= 1'b0;
         btn_armed <= 1'b0;
         blink_cnt <= '0;
         icon_on   <= 1'b1;
      end else begin
         state     <= state_nxt;
         btn_q     <= bus.pause_btn;
         btn_armed <= 1'b1;
         blink_cnt <= blink_nxt;
         icon_on   <= icon_nxt;
      end
   end

`ifdef PAUSE_COUNTDOWN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         digit <= 2'd3;
      end else begin
         cnt   <= cnt_nxt;
         digit <= digit_nxt;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      blink_nxt = blink_cnt;
      icon_nxt  = icon_on;
`ifdef PAUSE_COUNTDOWN_EN
      cnt_nxt   = cnt;
      digit_nxt = digit;
`endif
      case (state)
         RUN: begin
            if (press) begin
               state_nxt = PAUSED;
               blink_nxt = '0;
               icon_nxt  = 1'b1;
            end
         end
         PAUSED: begin
            if (press) begin
`ifdef PAUSE_COUNTDOWN_EN
               state_nxt = COUNT;
               cnt_nxt   = '0;
               digit_nxt = 2'd3;
`else
               state_nxt = RUN;
`endif
            end else if (blink_cnt == BLINK_LAST) begin
               blink_nxt = '0;
               icon_nxt  = ~icon_on;
            end else begin
               blink_nxt = blink_cnt + 1'b1;
            end
         end
`ifdef PAUSE_COUNTDOWN_EN
         COUNT: begin
            // A press on the final count still lands in PAUSED rather than RUN.
            if (press) begin
               state_nxt = PAUSED;
               blink_nxt = '0;
               icon_nxt  = 1'b1;
            end else if (cnt == COUNT_LAST) begin
               cnt_nxt = '0;
               if (digit == 2'd1) begin
                  state_nxt = RUN;
               end else begin
                  digit_nxt = digit - 2'd1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
`endif
         default: state_nxt = RUN;
      endcase
   end

`ifdef PAUSE_COUNTDOWN_EN
   assign glyph_digit = digit;
`else
   assign glyph_digit = 2'd3;
`endif

   pause_glyph_gen #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_glyph (
      .icon_on (icon_on),
      .state   (state),
      .digit   (glyph_digit),
      .red     (ov_red),
      .green   (ov_green)
   );

   // Output register: every output reflects the state and frame of the previous cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         red_q     <= '0;
         green_q   <= '0;
         game_en_q <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         if (state == RUN) begin
            red_q   <= bus.red_in;
            green_q <= bus.green_in;
         end else begin
            red_q   <= ov_red;
            green_q <= ov_green;
         end
         game_en_q <= (state == RUN);
         paused_q  <= (state != RUN);
      end
   end

   assign bus.red_out   = red_q;
   assign bus.green_out = green_q;
   assign bus.game_en   = game_en_q;
   assign bus.paused    = paused_q;

endmodule

// File: tb/tb_pause_overlay_ctrl.sv
// Directed bench for pause_overlay_ctrl (8x8 matrix, BLINK_CYCLES=4, COUNT_CYCLES=6); follows PAUSE_COUNTDOWN_EN.
module tb_pause_overlay_ctrl;

   localparam int ROWS = 8;
   localparam int COLS = 8;

   typedef logic [ROWS-1:0][COLS-1:0] frame_t;

   typedef struct {
      logic   rst;
      logic   btn;
      frame_t in_r;
      frame_t in_g;
      frame_t exp_r;
      frame_t exp_g;
      logic   exp_en;
      logic   exp_ps;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];

   pause_overlay_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   pause_overlay_ctrl #(
      .ROWS         (ROWS),
      .COLS         (COLS),
      .BLINK_CYCLES (4),
      .COUNT_CYCLES (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic frame_t fill(input logic [7:0] b);
      frame_t f;
      for (int r = 0; r < ROWS; r++) f[r] = b;
      return f;
   endfunction

   function automatic frame_t ramp();
      frame_t f;
      for (int r = 0; r < ROWS; r++) f[r] = 8'(r * 19 + 7);
      return f;
   endfunction

   function automatic frame_t pause_frame();
      frame_t f = '0;
      for (int r = 1; r <= 6; r++) f[r] = 8'h36;
      return f;
   endfunction

   // Digit glyph occupies rows 1..5, columns 2..4.
   function automatic frame_t digit_frame(input int d);
      frame_t f = '0;
      case (d)
         3: begin f[1]=8'h1C; f[2]=8'h10; f[3]=8'h1C; f[4]=8'h10; f[5]=8'h1C; end
         2: begin f[1]=8'h1C; f[2]=8'h10; f[3]=8'h1C; f[4]=8'h04; f[5]=8'h1C; end
         1: begin f[1]=8'h08; f[2]=8'h0C; f[3]=8'h08; f[4]=8'h08; f[5]=8'h1C; end
         default: f = '0;
      endcase
      return f;
   endfunction

   task automatic add(input logic rst, input logic btn, input frame_t ir, input frame_t ig,
                      input frame_t er, input frame_t eg, input logic en, input logic ps);
      vec_t v;
      v.rst = rst; v.btn = btn; v.in_r = ir; v.in_g = ig;
      v.exp_r = er; v.exp_g = eg; v.exp_en = en; v.exp_ps = ps;
      vecs.push_back(v);
   endtask

   task automatic cyc(input logic rst, input logic btn, input frame_t ir, input frame_t ig);
      reset         = rst;
      bus.pause_btn = btn;
      bus.red_in    = ir;
      bus.green_in  = ig;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input frame_t er, input frame_t eg,
                        input logic en, input logic ps);
      n_checks++;
      if (bus.red_out !== er || bus.green_out !== eg || bus.game_en !== en || bus.paused !== ps) begin
         n_fail++;
         $display("FAIL %s: got red=%h green=%h game_en=%b paused=%b, required red=%h green=%h game_en=%b paused=%b",
                  name, bus.red_out, bus.green_out, bus.game_en, bus.paused, er, eg, en, ps);
      end
   endtask

   initial begin
      frame_t a5, n5a, rp, nrp, g, z;
      a5  = fill(8'hA5);
      n5a = fill(8'h5A);
      rp  = ramp();
      nrp = ~rp;
      g   = pause_frame();
      z   = '0;

      // Reset, then passthrough with two distinct frames.
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, a5, n5a, z, z, 1'b0, 1'b0);
      add(1'b0, 1'b0, a5, n5a, a5, n5a, 1'b1, 1'b0);
      add(1'b0, 1'b0, rp, nrp, rp, nrp, 1'b1, 1'b0);
      // Press and hold 20 cycles: glyph blinks 4 on / 4 off, no re-toggle.
      add(1'b0, 1'b1, a5, n5a, a5, n5a, 1'b1, 1'b0);
      for (int k = 0; k <= 20; k++) begin
         frame_t e;
         e = (((k / 4) % 2) == 0) ? g : z;
         add(1'b0, (k != 19), rp, nrp, e, e, 1'b0, 1'b1);
      end
`ifdef PAUSE_COUNTDOWN_EN
      // Second press: 3, 2, 1 in red for 6 cycles each, then passthrough.
      for (int j = 0; j < 18; j++)
         add(1'b0, (j == 0), rp, nrp, digit_frame(3 - j / 6), z, 1'b0, 1'b1);
      add(1'b0, 1'b0, a5, n5a, a5, n5a, 1'b1, 1'b0);
`else
      // Second press resumes immediately; re-entering pause restarts with the glyph on.
      add(1'b0, 1'b1, rp, nrp, rp, nrp, 1'b1, 1'b0);
      add(1'b0, 1'b0, a5, n5a, a5, n5a, 1'b1, 1'b0);
      add(1'b0, 1'b1, rp, nrp, rp, nrp, 1'b1, 1'b0);
      add(1'b0, 1'b0, a5, n5a, g, g, 1'b0, 1'b1);
      add(1'b0, 1'b0, a5, n5a, g, g, 1'b0, 1'b1);
      add(1'b0, 1'b1, a5, n5a, g, g, 1'b0, 1'b1);
      add(1'b0, 1'b0, rp, nrp, rp, nrp, 1'b1, 1'b0);
`endif

      foreach (vecs[i]) begin
         cyc(vecs[i].rst, vecs[i].btn, vecs[i].in_r, vecs[i].in_g);
         check($sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_en, vecs[i].exp_ps);
      end

`ifdef PAUSE_COUNTDOWN_EN
      // Press on the cycle of the digit-1 terminal count: back to PAUSED, glyph on.
      cyc(1'b0, 1'b1, a5, n5a); check("t4_enter_run", a5, n5a, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, a5, n5a); check("t4_paused", g, g, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, a5, n5a); check("t4_resume_press", g, g, 1'b0, 1'b1);
      for (int k = 1; k <= 17; k++) begin
         cyc(1'b0, 1'b0, rp, nrp);
         if (k == 1)  check("t4_digit3", digit_frame(3), z, 1'b0, 1'b1);
         if (k == 7)  check("t4_digit2", digit_frame(2), z, 1'b0, 1'b1);
         if (k == 13) check("t4_digit1", digit_frame(1), z, 1'b0, 1'b1);
      end
      cyc(1'b0, 1'b1, rp, nrp); check("t4_term_cycle", digit_frame(1), z, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, rp, nrp); check("t4_edge_wins", g, g, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, rp, nrp);
      cyc(1'b0, 1'b0, rp, nrp);
      cyc(1'b0, 1'b0, rp, nrp); check("t4_glyph_last", g, g, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, rp, nrp); check("t4_blank", z, z, 1'b0, 1'b1);

      // Reset mid-COUNT with the button held through release.
      cyc(1'b0, 1'b1, a5, n5a);
      cyc(1'b0, 1'b1, a5, n5a); check("t5_in_count", digit_frame(3), z, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, a5, n5a);
`else
      // Press on the blink wrap cycle: the press wins and play resumes.
      cyc(1'b0, 1'b1, a5, n5a); check("t4_enter_run", a5, n5a, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, a5, n5a); check("t4_paused", g, g, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, a5, n5a);
      cyc(1'b0, 1'b0, a5, n5a);
      cyc(1'b0, 1'b1, a5, n5a); check("t4_wrap_press", g, g, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, rp, nrp); check("t4_resumed", rp, nrp, 1'b1, 1'b0);

      // Reset mid-pause with the button held through release.
      cyc(1'b0, 1'b1, a5, n5a);
      cyc(1'b0, 1'b1, a5, n5a); check("t5_in_pause", g, g, 1'b0, 1'b1);
`endif
      cyc(1'b1, 1'b1, a5, n5a); check("t5_reset0", z, z, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, a5, n5a); check("t5_reset1", z, z, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, rp, nrp); check("t5_release", rp, nrp, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, a5, n5a); check("t5_held1", a5, n5a, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, rp, nrp); check("t5_held2", rp, nrp, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, a5, n5a); check("t5_new_press", a5, n5a, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, rp, nrp); check("t5_paused_again", g, g, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
